// File: rtl/code_loader.sv
// Loads framed program words [len_hi len_lo payload(4*N) csum] into the 256-word instruction memory.
// Each word is written one cycle after its 4th byte. in_ready stalls nothing and depends only on state.
module code_loader (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        mem_we,
  output logic [7:0]  mem_addr,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [8:0]  word_cnt
);

  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERR} state_t;

  state_t      state, state_nxt;
  logic [7:0]  len_hi;
  logic [15:0] len;
  logic [15:0] len_full;
  logic [1:0]  byte_idx;
  logic [8:0]  word_idx;
  logic [23:0] shreg;
  logic [7:0]  csum;
  logic        accept;
  logic        word_end;
  logic        start_ok;

  assign in_ready = (state == LEN_HI) || (state == LEN_LO) || (state == DATA) || (state == CSUM);
  assign busy     = in_ready;
  assign done     = (state == DONE);
  assign err      = (state == ERR);
  assign accept   = in_valid && in_ready;
  assign word_end = accept && (state == DATA) && (byte_idx == 2'd3);
  assign start_ok = start && !busy;
  assign len_full = {len_hi, in_data};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE, ERR: if (start) state_nxt = LEN_HI;
      LEN_HI: if (accept) state_nxt = LEN_LO;
      LEN_LO: begin
        if (accept) begin
          if (len_full == 16'd0)        state_nxt = CSUM;
          else if (len_full > 16'd256)  state_nxt = ERR;
          else                          state_nxt = DATA;
        end
      end
      // words written so far equals N once this word lands
      DATA: if (word_end && (({7'd0, word_idx} + 16'd1) == len)) state_nxt = CSUM;
      CSUM: if (accept) state_nxt = (in_data == csum) ? DONE : ERR;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_hi    <= '0;
      len       <= '0;
      byte_idx  <= '0;
      word_idx  <= '0;
      shreg     <= '0;
      csum      <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      word_cnt  <= '0;
    end else begin
      mem_we <= 1'b0;
      if (start_ok) begin
        word_cnt <= '0;
        csum     <= '0;
        word_idx <= '0;
        byte_idx <= '0;
      end
      if (accept) begin
        case (state)
          LEN_HI: len_hi <= in_data;
          LEN_LO: len    <= len_full;
          DATA: begin
            csum     <= csum ^ in_data;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              mem_we    <= 1'b1;
              mem_addr  <= word_idx[7:0];
              mem_wdata <= {shreg, in_data};
              word_idx  <= word_idx + 9'd1;
              word_cnt  <= word_cnt + 9'd1;
            end else begin
              shreg <= {shreg[15:0], in_data};
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_code_loader.sv
// Directed bench for code_loader: frame loads, checksum errors, oversize length, gaps and reset.
module tb_code_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready, mem_we, busy, done, err;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [8:0]  word_cnt;

  int nvec = 0;
  int nerr = 0;
  int wr_total = 0;
  int base;
  logic [7:0]  wr_addr [0:63];
  logic [31:0] wr_data [0:63];

  logic [7:0] f_good [0:10] = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44,
                                8'h55, 8'h66, 8'h77, 8'h88, 8'h88};
  int gaps [0:10] = '{2, 0, 3, 1, 0, 2, 1, 3, 0, 2, 1};

  always #5 clk = ~clk;

  code_loader dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .err(err), .word_cnt(word_cnt)
  );

  always @(negedge clk) begin
    if (mem_we) begin
      wr_addr[wr_total % 64] = mem_addr;
      wr_data[wr_total % 64] = mem_wdata;
      wr_total = wr_total + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // gap idle cycles precede the byte; stp pulses start in the first idle cycle
  task automatic send_byte(input logic [7:0] b, input int gap, input logic stp);
    int n;
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      start    = stp && (i == 0);
    end
    @(negedge clk);
    start    = 1'b0;
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_before_byte", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_done_err", {30'd0, done, err}, 32'd0);
    chk("rst_mem", {23'd0, mem_we, mem_addr}, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_word_cnt", {23'd0, word_cnt}, 32'd0);

    // reset overrides a simultaneous start
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("rst_beats_start", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // two-word load with good checksum
    base = wr_total;
    do_start();
    chk("start_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 11; i++) send_byte(f_good[i], 0, 1'b0);
    chk("good_done", {30'd0, done, err}, 32'd2);
    chk("good_word_cnt", {23'd0, word_cnt}, 32'd2);
    chk("good_nwr", wr_total - base, 32'd2);
    chk("good_addr0", {24'd0, wr_addr[base % 64]}, 32'd0);
    chk("good_data0", wr_data[base % 64], 32'h11223344);
    chk("good_addr1", {24'd0, wr_addr[(base + 1) % 64]}, 32'd1);
    chk("good_data1", wr_data[(base + 1) % 64], 32'h55667788);
    chk("good_idle_busy", {31'd0, busy}, 32'd0);

    // bad checksum: writes still happen, then err
    base = wr_total;
    do_start();
    chk("restart_clears", {21'd0, done, err, word_cnt}, 32'd0);
    for (int i = 0; i < 10; i++) send_byte(f_good[i], 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    chk("bad_status", {30'd0, done, err}, 32'd1);
    chk("bad_nwr", wr_total - base, 32'd2);
    chk("bad_data1", wr_data[(base + 1) % 64], 32'h55667788);
    chk("bad_word_cnt", {23'd0, word_cnt}, 32'd2);

    // N = 257 rejected straight after the length
    base = wr_total;
    do_start();
    send_byte(8'h01, 0, 1'b0);
    send_byte(8'h01, 0, 1'b0);
    chk("len257_err", {29'd0, err, done, in_ready}, 32'd4);
    chk("len257_nwr", wr_total - base, 32'd0);
    repeat (3) @(negedge clk);
    chk("len257_nwr_later", wr_total - base, 32'd0);

    // N = 0 then checksum 00
    base = wr_total;
    do_start();
    chk("err_cleared_by_start", {31'd0, err}, 32'd0);
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    chk("len0_done", {30'd0, done, err}, 32'd2);
    chk("len0_word_cnt", {23'd0, word_cnt}, 32'd0);
    chk("len0_nwr", wr_total - base, 32'd0);

    // gaps with start pulses while busy
    base = wr_total;
    do_start();
    for (int i = 0; i < 11; i++) begin
      send_byte(f_good[i], gaps[i], (i == 3) || (i == 7) || (i == 10));
      if (i == 6) chk("gap_stall_busy", {31'd0, busy}, 32'd1);
    end
    chk("gap_done", {30'd0, done, err}, 32'd2);
    chk("gap_word_cnt", {23'd0, word_cnt}, 32'd2);
    chk("gap_nwr", wr_total - base, 32'd2);
    chk("gap_data0", wr_data[base % 64], 32'h11223344);
    chk("gap_addr1", {24'd0, wr_addr[(base + 1) % 64]}, 32'd1);
    chk("gap_data1", wr_data[(base + 1) % 64], 32'h55667788);

    // reset mid-load after 6 payload bytes
    base = wr_total;
    do_start();
    for (int i = 0; i < 8; i++) send_byte(f_good[i], 0, 1'b0);
    chk("mid_nwr", wr_total - base, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_word_cnt", {23'd0, word_cnt}, 32'd0);
    chk("mid_rst_mem_we", {31'd0, mem_we}, 32'd0);
    base = wr_total;
    do_start();
    for (int i = 0; i < 11; i++) send_byte(f_good[i], 0, 1'b0);
    chk("reload_addr0", {24'd0, wr_addr[base % 64]}, 32'd0);
    chk("reload_data0", wr_data[base % 64], 32'h11223344);
    chk("reload_done", {30'd0, done, err}, 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
